// File: rtl/separable_islip_allocator.sv
// Separable two-stage switch allocator for the router SA stage.
// Stage 1 picks one VC per input (round-robin, lock holders first); stage 2
// picks one input per output (round-robin). Pointers advance only for pairs
// that win both stages (iSLIP). Optional per-output locking keeps an output
// bound to one (input, VC) from a packet's head flit to its tail flit.
module separable_islip_allocator #(
  parameter int PORT_NUM = 5,
  parameter int VC_NUM   = 2,
  parameter bit LOCK_EN  = 1'b1,
  localparam int PTR_W   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int OP_W    = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]          request_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0][OP_W-1:0] out_port_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]          tail_i,
  input  logic [PORT_NUM-1:0]                      out_ready_i,
  output logic [PORT_NUM-1:0][VC_NUM-1:0]          grant_o
);

  // Registered arbitration state
  logic [PORT_NUM-1:0][PTR_W-1:0] vc_ptr_reg;
  logic [PORT_NUM-1:0][OP_W-1:0]  ip_ptr_reg;
  logic [PORT_NUM-1:0]            lock_vld_reg;
  logic [PORT_NUM-1:0][OP_W-1:0]  lock_ip_reg;
  logic [PORT_NUM-1:0][PTR_W-1:0] lock_vc_reg;

  // Per-(input, VC) eligibility and lock ownership
  logic [PORT_NUM-1:0][VC_NUM-1:0] eligible;
  logic [PORT_NUM-1:0][VC_NUM-1:0] holder;

  // Stage-1 result per input
  logic [PORT_NUM-1:0]            cand_vld;
  logic [PORT_NUM-1:0][PTR_W-1:0] cand_vc;
  logic [PORT_NUM-1:0][OP_W-1:0]  cand_out;

  // Stage-2 result per output
  logic [PORT_NUM-1:0]            out_win_vld;
  logic [PORT_NUM-1:0][OP_W-1:0]  out_win_ip;
  logic [PORT_NUM-1:0][PTR_W-1:0] out_win_vc;
  logic [PORT_NUM-1:0]            out_win_tail;

  // Input rows that won an output this cycle
  logic [PORT_NUM-1:0] in_won;

  genvar gi, gv;

  generate
    for (gi = 0; gi < PORT_NUM; gi++) begin : g_elig_in
      for (gv = 0; gv < VC_NUM; gv++) begin : g_elig_vc
        logic [OP_W-1:0] tgt;
        logic            legal;
        logic            mine;
        assign tgt   = out_port_i[gi][gv];
        // Out-of-range targets are treated as no request at all.
        assign legal = (int'(tgt) < PORT_NUM);
        assign mine  = legal && lock_vld_reg[tgt] &&
                       (lock_ip_reg[tgt] == OP_W'(gi)) &&
                       (lock_vc_reg[tgt] == PTR_W'(gv));
        assign eligible[gi][gv] = request_i[gi][gv] && legal && out_ready_i[tgt] &&
                                  (!lock_vld_reg[tgt] || mine);
        assign holder[gi][gv]   = eligible[gi][gv] && mine;
      end
    end

    for (gi = 0; gi < PORT_NUM; gi++) begin : g_stage1
      logic [VC_NUM-1:0] pick_mask;
      logic              vld;
      logic [PTR_W-1:0]  vc;
      // A VC continuing a locked packet pre-empts the round-robin pointer.
      assign pick_mask = (|holder[gi]) ? holder[gi] : eligible[gi];

      // Round-robin VC pick: first set bit at or after vc_ptr, then wrap.
      always_comb begin
        vld = 1'b0;
        vc  = '0;
        for (int j = 0; j < VC_NUM; j++) begin
          if (!vld && pick_mask[j] && (j >= int'(vc_ptr_reg[gi]))) begin
            vld = 1'b1;
            vc  = PTR_W'(j);
          end
        end
        for (int j = 0; j < VC_NUM; j++) begin
          if (!vld && pick_mask[j]) begin
            vld = 1'b1;
            vc  = PTR_W'(j);
          end
        end
      end

      assign cand_vld[gi] = vld;
      assign cand_vc[gi]  = vc;
      assign cand_out[gi] = out_port_i[gi][vc];
    end

    for (gi = 0; gi < PORT_NUM; gi++) begin : g_stage2
      logic [PORT_NUM-1:0] req_here;
      logic                vld;
      logic [OP_W-1:0]     ip;
      logic [PTR_W-1:0]    vc;
      logic                tail;

      // Collect inputs whose stage-1 candidate targets this output.
      always_comb begin
        req_here = '0;
        for (int j = 0; j < PORT_NUM; j++) begin
          req_here[j] = cand_vld[j] && (cand_out[j] == OP_W'(gi));
        end
      end

      // Round-robin input pick starting at ip_ptr; lock exclusivity is
      // already enforced by eligibility, so only the holder can appear here.
      always_comb begin
        vld  = 1'b0;
        ip   = '0;
        vc   = '0;
        tail = 1'b0;
        for (int j = 0; j < PORT_NUM; j++) begin
          if (!vld && req_here[j] && (j >= int'(ip_ptr_reg[gi]))) begin
            vld  = 1'b1;
            ip   = OP_W'(j);
            vc   = cand_vc[j];
            tail = tail_i[j][cand_vc[j]];
          end
        end
        for (int j = 0; j < PORT_NUM; j++) begin
          if (!vld && req_here[j]) begin
            vld  = 1'b1;
            ip   = OP_W'(j);
            vc   = cand_vc[j];
            tail = tail_i[j][cand_vc[j]];
          end
        end
      end

      assign out_win_vld[gi]  = vld;
      assign out_win_ip[gi]   = ip;
      assign out_win_vc[gi]   = vc;
      assign out_win_tail[gi] = tail;
    end
  endgenerate

  // An input is granted when some output picked it in stage 2.
  always_comb begin
    in_won = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int i = 0; i < PORT_NUM; i++) begin
        if (out_win_vld[o] && (out_win_ip[o] == OP_W'(i))) begin
          in_won[i] = 1'b1;
        end
      end
    end
  end

  generate
    for (gi = 0; gi < PORT_NUM; gi++) begin : g_grant_in
      for (gv = 0; gv < VC_NUM; gv++) begin : g_grant_vc
        assign grant_o[gi][gv] = !rst && in_won[gi] && (cand_vc[gi] == PTR_W'(gv));
      end
    end
  endgenerate

  // iSLIP pointer advance and packet lock tracking, only for final grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      vc_ptr_reg   <= '0;
      ip_ptr_reg   <= '0;
      lock_vld_reg <= '0;
      lock_ip_reg  <= '0;
      lock_vc_reg  <= '0;
    end else begin
      for (int i = 0; i < PORT_NUM; i++) begin
        if (in_won[i]) begin
          vc_ptr_reg[i] <= (int'(cand_vc[i]) == VC_NUM - 1) ? '0 : cand_vc[i] + 1'b1;
        end
      end
      for (int o = 0; o < PORT_NUM; o++) begin
        if (out_win_vld[o]) begin
          ip_ptr_reg[o] <= (int'(out_win_ip[o]) == PORT_NUM - 1) ? '0 : out_win_ip[o] + 1'b1;
        end
        // Non-tail grant (re)arms the lock; the holder's tail grant releases it.
        if (LOCK_EN && out_win_vld[o]) begin
          lock_vld_reg[o] <= !out_win_tail[o];
          lock_ip_reg[o]  <= out_win_ip[o];
          lock_vc_reg[o]  <= out_win_vc[o];
        end
      end
    end
  end

endmodule

// File: tb/tb_separable_islip_allocator.sv
// Directed bench for separable_islip_allocator (5 ports, 2 VCs, locking on).
// Expected grant vectors are queued when a step is driven and compared on the
// following falling edge.
module tb_separable_islip_allocator;

  localparam int P  = 5;
  localparam int V  = 2;
  localparam int OW = 3;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [P-1:0][V-1:0]         request_i;
  logic [P-1:0][V-1:0][OW-1:0] out_port_i;
  logic [P-1:0][V-1:0]         tail_i;
  logic [P-1:0]                out_ready_i;
  logic [P-1:0][V-1:0]         grant_o;

  logic [P*V-1:0] exp_q[$];
  string          tag_q[$];
  int             n_checks = 0;
  int             n_fail   = 0;

  separable_islip_allocator #(.PORT_NUM(P), .VC_NUM(V), .LOCK_EN(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .request_i  (request_i),
    .out_port_i (out_port_i),
    .tail_i     (tail_i),
    .out_ready_i(out_ready_i),
    .grant_o    (grant_o)
  );

  always #5 clk = ~clk;

  // Single-bit grant vector for (input i, VC v)
  function automatic logic [P*V-1:0] g(input int i, input int v);
    logic [P*V-1:0] r;
    r = '0;
    r[i*V+v] = 1'b1;
    return r;
  endfunction

  task automatic clear_in();
    request_i   = '0;
    tail_i      = '0;
    out_port_i  = '0;
    out_ready_i = '1;
  endtask

  task automatic req(input int i, input int v, input int o, input bit t);
    request_i[i][v]  = 1'b1;
    out_port_i[i][v] = OW'(o);
    tail_i[i][v]     = t;
  endtask

  task automatic check_out();
    logic [P*V-1:0] e;
    string          t;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: grant_o=%b expected none queued", grant_o);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (grant_o === e) else begin
        n_fail++;
        $error("FAIL %s: grant_o=%b expected=%b", t, grant_o, e);
      end
      $display("check %s: grant_o=%b expected=%b", t, grant_o, e);
    end
  endtask

  // Inputs are already driven; queue expectation, sample mid-cycle, advance.
  task automatic expect_cycle(input string tag, input logic [P*V-1:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_in();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Reset with everything requesting: grants stay zero
    clear_in();
    rst       = 1'b1;
    request_i = '1;
    tail_i    = '1;
    for (int i = 0; i < P; i++) begin
      out_port_i[i][0] = OW'(i);
      out_port_i[i][1] = OW'(i);
    end
    expect_cycle("rst_cycle0", '0);
    expect_cycle("rst_cycle1", '0);
    rst = 1'b0;
    expect_cycle("post_rst_all_vc0", g(0,0) | g(1,0) | g(2,0) | g(3,0) | g(4,0));

    // Input round-robin over VCs
    do_reset();
    req(0, 0, 2, 1'b1);
    req(0, 1, 2, 1'b1);
    expect_cycle("in_rr_0", g(0,0));
    expect_cycle("in_rr_1", g(0,1));
    expect_cycle("in_rr_2", g(0,0));
    expect_cycle("in_rr_3", g(0,1));

    // Output round-robin; stage-2 loser keeps its VC pointer
    do_reset();
    req(1, 0, 1, 1'b1);
    expect_cycle("out_rr_single", g(1,0));
    clear_in();
    req(0, 0, 1, 1'b1);
    req(2, 0, 1, 1'b1);
    expect_cycle("out_rr_ptr2", g(2,0));
    clear_in();
    req(0, 0, 3, 1'b1);
    req(0, 1, 4, 1'b1);
    expect_cycle("loser_vc_ptr_kept", g(0,0));

    // Output pointer rotation and wrap from 4 back to 0
    do_reset();
    req(0, 0, 3, 1'b1);
    req(1, 0, 3, 1'b1);
    req(4, 0, 3, 1'b1);
    expect_cycle("wrap_0", g(0,0));
    expect_cycle("wrap_1", g(1,0));
    expect_cycle("wrap_4", g(4,0));
    expect_cycle("wrap_back_0", g(0,0));

    // Illegal targets are ignored
    do_reset();
    req(3, 0, 5, 1'b1);
    req(3, 1, 1, 1'b1);
    req(2, 0, 7, 1'b1);
    expect_cycle("illegal_port", g(3,1));

    // Packet lock: head, two bodies, tail, then the waiting input
    do_reset();
    req(2, 1, 0, 1'b0);
    expect_cycle("lock_head", g(2,1));
    req(4, 0, 0, 1'b1);
    expect_cycle("lock_body0", g(2,1));
    expect_cycle("lock_body1", g(2,1));
    req(2, 1, 0, 1'b1);
    expect_cycle("lock_tail", g(2,1));
    clear_in();
    req(4, 0, 0, 1'b1);
    expect_cycle("lock_released", g(4,0));

    // Lock held through holder idle and backpressure
    do_reset();
    req(2, 1, 0, 1'b0);
    expect_cycle("idle_head", g(2,1));
    clear_in();
    req(4, 0, 0, 1'b1);
    expect_cycle("idle_gap0", '0);
    req(1, 0, 3, 1'b1);
    expect_cycle("idle_gap1_other_out", g(1,0));
    clear_in();
    req(4, 0, 0, 1'b1);
    req(2, 1, 0, 1'b0);
    out_ready_i[0] = 1'b0;
    expect_cycle("idle_no_credit", '0);
    out_ready_i[0] = 1'b1;
    req(2, 1, 0, 1'b1);
    expect_cycle("idle_tail", g(2,1));
    clear_in();
    req(4, 0, 0, 1'b1);
    expect_cycle("idle_released", g(4,0));

    // Output-ready masking
    do_reset();
    out_ready_i[3] = 1'b0;
    req(0, 0, 3, 1'b1);
    req(0, 1, 1, 1'b1);
    expect_cycle("bp_masked", g(0,1));
    clear_in();
    req(0, 0, 3, 1'b1);
    expect_cycle("bp_ready", g(0,0));

    // Reset mid-packet drops the lock
    do_reset();
    req(2, 1, 0, 1'b0);
    expect_cycle("midrst_head", g(2,1));
    req(4, 0, 0, 1'b1);
    rst = 1'b1;
    expect_cycle("midrst_in_reset", '0);
    rst = 1'b0;
    clear_in();
    req(4, 0, 0, 1'b1);
    expect_cycle("midrst_lock_dropped", g(4,0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/separable_islip_allocator.md
# separable_islip_allocator

Parametrised switch allocator for the NoC router's SA stage, succeeding the separable input-first allocator. It has two round-robin stages: per-input over VCs, then per-output over inputs. It adds three behaviours: iSLIP-style pointer update (pointers advance only on final grant), output-ready masking from downstream credit, and optional per-output packet locking for wormhole traffic. Grants are combinational from registered arbitration state and drive the crossbar select and VC buffer read enables.

## Interface

- PORT_NUM, 5, number of router ports (inputs = outputs); minimum 2
- VC_NUM, 2, virtual channels per input port; minimum 1
- LOCK_EN, 1, 1 = hold output for a packet from head to tail, 0 = per-flit allocation
- PTR_W (local), max(1, $clog2(VC_NUM)); OP_W (local), max(1, $clog2(PORT_NUM))

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- request_i  in  [PORT_NUM][VC_NUM]  VC v of input i holds a flit needing the switch
- out_port_i  in  [PORT_NUM][VC_NUM][OP_W]  target output index of that flit; values >= PORT_NUM are illegal and treated as no request
- tail_i  in  [PORT_NUM][VC_NUM]  requesting flit is a tail (a head+tail single-flit packet has tail=1)
- out_ready_i  in  [PORT_NUM]  output o has downstream credit this cycle
- grant_o  out  [PORT_NUM][VC_NUM]  one-hot-or-zero per input; VC v of input i is granted this cycle

## Operation

- Eligibility: request (i,v) is eligible iff request_i[i][v] = 1, o = out_port_i[i][v] is legal, out_ready_i[o] = 1, and output o is unlocked or locked to exactly (i,v).
- Stage 1: per input i, a round-robin over eligible VCs starts at vc_ptr[i]. A VC holding a lock on its target output beats the pointer. The result is at most one candidate per input.
- Stage 2: per output o, a round-robin over inputs whose candidate targets o starts at ip_ptr[o]. If o is locked, only the lock holder may win.
- grant_o[i][v] = 1 iff (i,v) won both stages. At most one grant per input row and at most one per output.
- Pointer update (iSLIP), only for granted pairs:
  - vc_ptr[i] ← (v+1) mod VC_NUM; ip_ptr[o] ← (i+1) mod PORT_NUM.
  - Losers in stage 2 leave vc_ptr[i] unchanged.
  - Outputs with no grant leave ip_ptr[o] unchanged.
- Lock state, per output: lock_vld[o], lock_ip[o], lock_vc[o].
  - Set: LOCK_EN=1 and grant (i,v)→o with tail_i[i][v]=0.
  - Clear: grant of the holder with tail_i=1.
  - While locked, a holder that does not request, or out_ready_i[o]=0, gives no grant on o. The lock is kept and ip_ptr[o] is frozen.
- LOCK_EN=0: lock registers are held at 0 and tail_i is ignored.

## Timing

- Zero-cycle request→grant latency: grant_o is combinational from inputs and registered pointers/locks.
- State (vc_ptr, ip_ptr, lock) updates on the clk edge ending the grant cycle. A pointer move or lock change is first visible in the next cycle's arbitration.
- Tail grant and lock release share a cycle: another input can win o the next cycle, never the same cycle.
- rst=1: grant_o forced to all-zero in that cycle regardless of inputs. At the edge, all vc_ptr ← 0, ip_ptr ← 0, lock_vld ← 0.
- Reset asserted mid-packet drops locks. After reset the allocator restarts from pointer 0 with no retained state.
- Wrap-around: a pointer at VC_NUM-1 or PORT_NUM-1 advances to 0. With VC_NUM=1, vc_ptr is a constant 0.
- Flipping out_ready_i within a cycle only affects that cycle's grants.

## Test plan

(PORT_NUM=5, VC_NUM=2, LOCK_EN=1, all out_ready_i=1 unless stated.)

- Reset: rst=1 for 2 cycles with request_i all ones and tail all ones → grant_o=0 in both cycles. First cycle after release, inputs 0..4 each with VC0→output i and VC1→output i → grant_o[i]=2'b01 for all i.
- Input RR: input 0 VC0 and VC1 → output 2, tail=1, held 4 cycles → grant_o[0] = 01, 10, 01, 10.
- Output RR/iSLIP: cycle 0, input 1 VC0→out 1 alone, granted, so ip_ptr[1]=2. Cycle 1, inputs 0 and 2 VC0→out 1 → input 2 granted, input 0 gets 00. vc_ptr[0] stays 0 (checked via input 0 VC0/VC1 both → unique outputs next cycle → VC0 wins).
- Packet lock: input 2 VC1→out 0 head (tail=0) granted. Input 4 VC0→out 0 requests from the next cycle. Input 2 VC1 sends body, body, tail → only input 2 granted for those 3 cycles. Input 4 is granted in the cycle after the tail.
- Lock hold with idle: after a locked head, input 2 VC1 deasserts for 2 cycles while input 4 requests out 0 → no grant on out 0. Lock retained; input 2 resumes with tail → granted.
- Backpressure: out_ready_i[3]=0; input 0 VC0→out 3, VC1→out 1 → grant_o[0]=2'b10 same cycle. Next cycle, out_ready_i[3]=1 and only VC0 requesting → grant_o[0]=2'b01.
